// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Encodings for reset, chip enable, write enable, bus widths and FSM states live here.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [SEL_W-1:0] SEL_FETCH = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    // Data normally wins; a pending fetch that has been passed over too often wins instead.
    function automatic grant_t pick_master(input logic i_req, input logic d_req,
                                           input logic starved);
        return (i_req && (!d_req || starved)) ? GNT_FETCH : GNT_DATA;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_timer.sv
// Transfer watchdog: reloads while not busy, then counts busy cycles down to zero.
// expired is high during the TIMEOUT-th enabled cycle after a reload.
module bus_timer
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch, load/store) arbiter onto a single-ported memory bus with
// starvation protection for fetches and a per-transfer watchdog.
//
// state | meaning
// IDLE  | bus free; arbitrate and latch the winning request
// BUSY  | mem_ce high with latched request; wait for mem_ack or timeout
// DONE  | ack/err pulse to the granted master; bus returns to IDLE
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,

    output logic              mem_ce,
    output logic              mem_we,
    output logic [SEL_W-1:0]  mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t    state;
    grant_t        grant;
    grant_t        next_grant;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          timer_clear;
    logic          timer_en;
    logic          timed_out;
    xfer_t         new_xfer;

    assign starved    = (starve_cnt == STARVE_LIM);
    assign next_grant = pick_master(i_req, d_req, starved);

    always_comb begin
        new_xfer = '0;
        if (next_grant == GNT_FETCH) begin
            new_xfer.we   = WRITE_DISABLE;
            new_xfer.sel  = SEL_FETCH;
            new_xfer.addr = i_addr;
        end else begin
            new_xfer.we    = d_we;
            new_xfer.sel   = d_sel;
            new_xfer.addr  = d_addr;
            new_xfer.wdata = d_wdata;
        end
    end

    assign timer_en    = (state == ST_BUSY);
    assign timer_clear = !timer_en;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timed_out)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= ST_IDLE;
            grant      <= GNT_FETCH;
            starve_cnt <= '0;
            i_rdata    <= '0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            d_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            mem_ce     <= CHIP_DISABLE;
            mem_we     <= WRITE_DISABLE;
            mem_sel    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    mem_ce <= CHIP_DISABLE;
                    mem_we <= WRITE_DISABLE;
                    if (i_req || d_req) begin
                        state     <= ST_BUSY;
                        grant     <= next_grant;
                        mem_ce    <= CHIP_ENABLE;
                        mem_we    <= new_xfer.we;
                        mem_sel   <= new_xfer.sel;
                        mem_addr  <= new_xfer.addr;
                        mem_wdata <= new_xfer.wdata;
                        if ((next_grant == GNT_FETCH) || !i_req) begin
                            starve_cnt <= '0;
                        end else if (!starved) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                // mem_ack beats a timeout landing on the same cycle.
                ST_BUSY: begin
                    if (mem_ack || timed_out) begin
                        state  <= ST_DONE;
                        mem_ce <= CHIP_DISABLE;
                        mem_we <= WRITE_DISABLE;
                        if (grant == GNT_FETCH) begin
                            i_ack   <= mem_ack;
                            i_err   <= !mem_ack;
                            i_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            d_ack   <= mem_ack;
                            d_err   <= !mem_ack;
                            d_rdata <= (mem_ack && (mem_we != WRITE_ENABLE)) ? mem_rdata : '0;
                        end
                    end
                end

                ST_DONE: begin
                    state   <= ST_IDLE;
                    i_rdata <= '0;
                    d_rdata <= '0;
                end

                default: begin
                    state  <= ST_IDLE;
                    mem_ce <= CHIP_DISABLE;
                    mem_we <= WRITE_DISABLE;
                end
            endcase
        end
    end

endmodule
